// File: rtl/slc3_datapath_p.sv
// SLC-3 datapath with a WIDTH parameter, bus-contention flag and a memory
// request/ack FSM with timeout that owns MDR loads from memory.
module slc3_datapath_p #(
   parameter int               WIDTH       = 16,
   parameter logic [WIDTH-1:0] PC_RESET    = 'h3000,
   parameter int               MEM_TIMEOUT = 15
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             gate_marmux,
   input  logic             gate_pc,
   input  logic             gate_alu,
   input  logic             gate_mdr,
   input  logic             ld_reg,
   input  logic             ld_ben,
   input  logic             ld_cc,
   input  logic             ld_ir,
   input  logic             ld_pc,
   input  logic             ld_mar,
   input  logic             ld_mdr,
   input  logic [1:0]       pcmux,
   input  logic             addr1mux,
   input  logic [1:0]       addr2mux,
   input  logic             drmux,
   input  logic             sr1mux,
   input  logic             sr2mux,
   input  logic [2:0]       aluk,
   input  logic             mem_start,
   input  logic             mem_we,
   input  logic             mem_ack,
   input  logic [WIDTH-1:0] mem_rdata,
   output logic             mem_req,
   output logic             mem_wr,
   output logic [WIDTH-1:0] mem_addr,
   output logic [WIDTH-1:0] mem_wdata,
   output logic             mem_done,
   output logic             mem_err,
   output logic [WIDTH-1:0] ir,
   output logic [WIDTH-1:0] pc,
   output logic [WIDTH-1:0] mar,
   output logic [WIDTH-1:0] mdr,
   output logic [2:0]       nzp,
   output logic             ben,
   output logic             bus_err
);

   localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q;
   logic [WIDTH-1:0]   ir_q, pc_q, mar_q, mdr_q;
   logic [WIDTH-1:0]   regs_q [8];
   logic [2:0]         nzp_q;
   logic               ben_q, bus_err_q;
   logic               mem_wr_q, mem_done_q, mem_err_q;
   logic [WIDTH-1:0]   mem_addr_q, mem_wdata_q;

   logic [WIDTH-1:0]   bus, alu_out, alu_b, sr1_val, sr2_val;
   logic [WIDTH-1:0]   addr1_val, addr2_val, marmux_val, pc_d;
   logic [WIDTH-1:0]   sext5, sext6, sext9, sext11;
   logic [2:0]         sr1_idx, dr_idx;
   logic               busy, timeout, ack_load, bus_conflict;
   logic               mem_done_d, mem_err_d;

   assign sext5  = {{(WIDTH-5){ir_q[4]}},   ir_q[4:0]};
   assign sext6  = {{(WIDTH-6){ir_q[5]}},   ir_q[5:0]};
   assign sext9  = {{(WIDTH-9){ir_q[8]}},   ir_q[8:0]};
   assign sext11 = {{(WIDTH-11){ir_q[10]}}, ir_q[10:0]};

   assign sr1_idx = sr1mux ? ir_q[8:6] : ir_q[11:9];
   assign dr_idx  = drmux  ? 3'd7      : ir_q[11:9];
   assign sr1_val = regs_q[sr1_idx];
   assign sr2_val = regs_q[ir_q[2:0]];
   assign alu_b   = sr2mux ? sext5 : sr2_val;

   assign addr1_val  = addr1mux ? sr1_val : pc_q;
   assign marmux_val = addr1_val + addr2_val;

   // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
   always_comb begin
      addr2_val = '0;
      case (addr2mux)
         2'b01:   addr2_val = sext6;
         2'b10:   addr2_val = sext9;
         2'b11:   addr2_val = sext11;
         default: addr2_val = '0;
      endcase
   end

   always_comb begin
      alu_out = '0;
      case (aluk)
         3'b000:  alu_out = sr1_val + alu_b;
         3'b001:  alu_out = sr1_val & alu_b;
         3'b010:  alu_out = ~sr1_val;
         3'b011:  alu_out = sr1_val;
         3'b100:  alu_out = sr1_val ^ alu_b;
         3'b101:  alu_out = sr1_val << 1;
         3'b110:  alu_out = $signed(sr1_val) >>> 1;
         default: alu_out = alu_b;
      endcase
   end

   // Fixed priority keeps the bus defined even when the control FSM double-gates.
   always_comb begin
      bus = '0;
      if (gate_marmux)   bus = marmux_val;
      else if (gate_pc)  bus = pc_q;
      else if (gate_alu) bus = alu_out;
      else if (gate_mdr) bus = mdr_q;
   end

   assign bus_conflict = (gate_marmux & (gate_pc | gate_alu | gate_mdr)) |
                         (gate_pc & (gate_alu | gate_mdr)) | (gate_alu & gate_mdr);

   always_comb begin
      pc_d = pc_q;
      case (pcmux)
         2'b00:   pc_d = pc_q + WIDTH'(1);
         2'b01:   pc_d = marmux_val;
         2'b10:   pc_d = bus;
         default: pc_d = pc_q;
      endcase
   end

   // Memory FSM: state register, next state, outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   assign busy    = (state_q == BUSY);
   assign timeout = !mem_ack && (cnt_q == CNT_W'(MEM_TIMEOUT - 1));

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (mem_start) state_d = BUSY;
         BUSY:    if (mem_ack || timeout) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      mem_req    = busy;
      mem_done_d = busy && (mem_ack || timeout);
      mem_err_d  = busy && timeout;
      ack_load   = busy && mem_ack && !mem_wr_q;
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q       <= '0;
         mem_wr_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_done_q  <= 1'b0;
         mem_err_q   <= 1'b0;
      end else begin
         mem_done_q <= mem_done_d;
         mem_err_q  <= mem_err_d;
         if (!busy && mem_start) begin
            cnt_q       <= '0;
            mem_wr_q    <= mem_we;
            mem_addr_q  <= mar_q;
            mem_wdata_q <= mdr_q;
         end else if (busy && !mem_ack) begin
            cnt_q <= cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ir_q      <= '0;
         pc_q      <= PC_RESET;
         mar_q     <= '0;
         mdr_q     <= '0;
         nzp_q     <= 3'b010;
         ben_q     <= 1'b0;
         bus_err_q <= 1'b0;
      end else begin
         if (ld_ir)  ir_q  <= bus;
         if (ld_pc)  pc_q  <= pc_d;
         if (ld_mar) mar_q <= bus;
         if (ack_load)    mdr_q <= mem_rdata;
         else if (ld_mdr) mdr_q <= bus;
         if (ld_cc) nzp_q <= {bus[WIDTH-1], bus == '0, !bus[WIDTH-1] && (bus != '0)};
         if (ld_ben) ben_q <= (ir_q[11] & nzp_q[2]) | (ir_q[10] & nzp_q[1]) | (ir_q[9] & nzp_q[0]);
         if (bus_conflict) bus_err_q <= 1'b1;
      end
   end

   // NOTE: the register file is architecturally cleared on reset, so this array is reset like flops.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 8; i++) regs_q[i] <= '0;
      end else if (ld_reg) begin
         regs_q[dr_idx] <= bus;
      end
   end

   assign mem_wr    = mem_wr_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign mem_done  = mem_done_q;
   assign mem_err   = mem_err_q;
   assign ir        = ir_q;
   assign pc        = pc_q;
   assign mar       = mar_q;
   assign mdr       = mdr_q;
   assign nzp       = nzp_q;
   assign ben       = ben_q;
   assign bus_err   = bus_err_q;

endmodule

// File: tb/tb_slc3_datapath_p.sv
// Directed bench for slc3_datapath_p: registers are loaded through the
// memory-read path, then each feature is exercised with hand-computed results.
module tb_slc3_datapath_p;

   localparam int W = 16;

   logic clk = 1'b0, reset = 1'b1;
   logic gate_marmux = 0, gate_pc = 0, gate_alu = 0, gate_mdr = 0;
   logic ld_reg = 0, ld_ben = 0, ld_cc = 0, ld_ir = 0, ld_pc = 0, ld_mar = 0, ld_mdr = 0;
   logic [1:0] pcmux = 2'b11, addr2mux = 0;
   logic addr1mux = 0, drmux = 0, sr1mux = 0, sr2mux = 0;
   logic [2:0] aluk = 0;
   logic mem_start = 0, mem_we = 0, mem_ack = 0;
   logic [W-1:0] mem_rdata = '0;
   logic mem_req, mem_wr, mem_done, mem_err, ben, bus_err;
   logic [W-1:0] mem_addr, mem_wdata, ir, pc, mar, mdr;
   logic [2:0] nzp;

   int vectors = 0, miscompares = 0;

   slc3_datapath_p #(.WIDTH(W), .PC_RESET('h3000), .MEM_TIMEOUT(15)) dut (
      .clk(clk), .reset(reset),
      .gate_marmux(gate_marmux), .gate_pc(gate_pc), .gate_alu(gate_alu), .gate_mdr(gate_mdr),
      .ld_reg(ld_reg), .ld_ben(ld_ben), .ld_cc(ld_cc), .ld_ir(ld_ir), .ld_pc(ld_pc),
      .ld_mar(ld_mar), .ld_mdr(ld_mdr), .pcmux(pcmux), .addr1mux(addr1mux), .addr2mux(addr2mux),
      .drmux(drmux), .sr1mux(sr1mux), .sr2mux(sr2mux), .aluk(aluk),
      .mem_start(mem_start), .mem_we(mem_we), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
      .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_done(mem_done), .mem_err(mem_err), .ir(ir), .pc(pc), .mar(mar), .mdr(mdr),
      .nzp(nzp), .ben(ben), .bus_err(bus_err)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_ctrl();
      gate_marmux = 0; gate_pc = 0; gate_alu = 0; gate_mdr = 0;
      ld_reg = 0; ld_ben = 0; ld_cc = 0; ld_ir = 0; ld_pc = 0; ld_mar = 0; ld_mdr = 0;
      pcmux = 2'b11; addr1mux = 0; addr2mux = 0; drmux = 0; sr1mux = 0; sr2mux = 0; aluk = 0;
      mem_start = 0; mem_we = 0; mem_ack = 0;
   endtask

   // Stimulus helper: a one-cycle-ack memory read deposits v into MDR.
   task automatic load_mdr(input logic [W-1:0] v);
      mem_we = 0; mem_start = 1;
      tick();
      mem_start = 0; mem_ack = 1; mem_rdata = v;
      tick();
      mem_ack = 0;
      tick();
   endtask

   task automatic set_ir(input logic [W-1:0] v);
      load_mdr(v);
      gate_mdr = 1; ld_ir = 1;
      tick();
      clear_ctrl();
   endtask

   task automatic write_r1_from_mdr(input logic [W-1:0] v);
      load_mdr(v);
      gate_mdr = 1; ld_reg = 1; drmux = 0;
      tick();
      clear_ctrl();
   endtask

   task automatic test_reset();
      vectors++; if (pc !== 16'h3000) begin miscompares++; $display("FAIL reset_pc: got %h want 3000", pc); end
      vectors++; if (nzp !== 3'b010) begin miscompares++; $display("FAIL reset_nzp: got %b want 010", nzp); end
      vectors++; if (ben !== 1'b0) begin miscompares++; $display("FAIL reset_ben: got %b want 0", ben); end
      vectors++; if (mem_req !== 1'b0 || mem_done !== 1'b0) begin miscompares++; $display("FAIL reset_mem: req %b done %b want 0 0", mem_req, mem_done); end
      vectors++; if (bus_err !== 1'b0) begin miscompares++; $display("FAIL reset_bus_err: got %b want 0", bus_err); end
      vectors++; if (mdr !== 16'h0000 || ir !== 16'h0000) begin miscompares++; $display("FAIL reset_regs: mdr %h ir %h want 0 0", mdr, ir); end
   endtask

   task automatic test_add_cc();
      set_ir(16'h1262);
      vectors++; if (ir !== 16'h1262) begin miscompares++; $display("FAIL ir_load: got %h want 1262", ir); end
      write_r1_from_mdr(16'hFFFF);
      vectors++; if (nzp !== 3'b010) begin miscompares++; $display("FAIL nzp_hold: got %b want 010", nzp); end
      // ADD R1,R1,#2 reads the old R1 while writing it
      sr1mux = 1; sr2mux = 1; aluk = 3'b000; gate_alu = 1; ld_reg = 1; ld_cc = 1;
      tick();
      clear_ctrl();
      vectors++; if (nzp !== 3'b001) begin miscompares++; $display("FAIL add_nzp: got %b want 001", nzp); end
      sr1mux = 1; aluk = 3'b011; gate_alu = 1; ld_mar = 1;
      tick();
      clear_ctrl();
      vectors++; if (mar !== 16'h0001) begin miscompares++; $display("FAIL add_r1: got %h want 0001", mar); end
   endtask

   task automatic test_alu_ops();
      // R1 = 0001, B = SEXT(#2) = 0002 unless sr2mux=0 (R2 = 0)
      logic [2:0]   op  [9] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0};
      logic         s2  [9] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      logic [W-1:0] exp [9] = '{16'h0003, 16'h0000, 16'hFFFE, 16'h0001, 16'h0003,
                                16'h0002, 16'h0000, 16'h0002, 16'h0001};
      for (int i = 0; i < 9; i++) begin
         sr1mux = 1; sr2mux = s2[i]; aluk = op[i]; gate_alu = 1; ld_mar = 1;
         tick();
         clear_ctrl();
         vectors++; if (mar !== exp[i]) begin miscompares++; $display("FAIL alu_op%0d: got %h want %h", i, mar, exp[i]); end
      end
      write_r1_from_mdr(16'h8002);
      sr1mux = 1; aluk = 3'b110; gate_alu = 1; ld_mar = 1; ld_cc = 1;
      tick();
      clear_ctrl();
      vectors++; if (mar !== 16'hC001) begin miscompares++; $display("FAIL alu_sar_neg: got %h want C001", mar); end
      vectors++; if (nzp !== 3'b100) begin miscompares++; $display("FAIL sar_nzp: got %b want 100", nzp); end
   endtask

   task automatic test_bus_contention();
      vectors++; if (bus_err !== 1'b0) begin miscompares++; $display("FAIL bus_err_pre: got %b want 0", bus_err); end
      gate_pc = 1; gate_alu = 1; ld_mar = 1;
      tick();
      clear_ctrl();
      vectors++; if (mar !== 16'h3000) begin miscompares++; $display("FAIL bus_priority: got %h want 3000", mar); end
      vectors++; if (bus_err !== 1'b1) begin miscompares++; $display("FAIL bus_err_set: got %b want 1", bus_err); end
      tick();
      vectors++; if (bus_err !== 1'b1) begin miscompares++; $display("FAIL bus_err_sticky: got %b want 1", bus_err); end
   endtask

   task automatic test_mem_read();
      load_mdr(16'h0040);
      gate_mdr = 1; ld_mar = 1;
      tick();
      clear_ctrl();
      mem_start = 1; mem_we = 0;
      tick();
      mem_start = 0;
      vectors++; if (mem_req !== 1'b1 || mem_wr !== 1'b0 || mem_addr !== 16'h0040) begin miscompares++; $display("FAIL rd_issue: req %b wr %b addr %h want 1 0 0040", mem_req, mem_wr, mem_addr); end
      for (int i = 0; i < 2; i++) begin
         tick();
         vectors++; if (mem_done !== 1'b0 || mem_req !== 1'b1) begin miscompares++; $display("FAIL rd_wait%0d: done %b req %b want 0 1", i, mem_done, mem_req); end
      end
      // third BUSY cycle: ack arrives alongside a competing ld_mdr
      mem_ack = 1; mem_rdata = 16'hABCD; gate_pc = 1; ld_mdr = 1;
      tick();
      clear_ctrl();
      vectors++; if (mem_done !== 1'b1 || mem_err !== 1'b0) begin miscompares++; $display("FAIL rd_done: done %b err %b want 1 0", mem_done, mem_err); end
      vectors++; if (mdr !== 16'hABCD) begin miscompares++; $display("FAIL rd_mdr: got %h want ABCD", mdr); end
      vectors++; if (mem_req !== 1'b0) begin miscompares++; $display("FAIL rd_req_drop: got %b want 0", mem_req); end
      mem_ack = 1; mem_rdata = 16'h1111;
      tick();
      mem_ack = 0;
      vectors++; if (mem_done !== 1'b0 || mdr !== 16'hABCD) begin miscompares++; $display("FAIL idle_ack: done %b mdr %h want 0 ABCD", mem_done, mdr); end
   endtask

   task automatic test_mem_write();
      mem_start = 1; mem_we = 1;
      tick();
      mem_start = 0; mem_we = 0;
      vectors++; if (mem_wr !== 1'b1 || mem_wdata !== 16'hABCD || mem_addr !== 16'h0040) begin miscompares++; $display("FAIL wr_issue: wr %b wdata %h addr %h want 1 ABCD 0040", mem_wr, mem_wdata, mem_addr); end
      mem_ack = 1; mem_rdata = 16'h5555;
      tick();
      mem_ack = 0;
      vectors++; if (mem_done !== 1'b1 || mdr !== 16'hABCD) begin miscompares++; $display("FAIL wr_done: done %b mdr %h want 1 ABCD", mem_done, mdr); end
      tick();
      vectors++; if (mem_done !== 1'b0) begin miscompares++; $display("FAIL wr_pulse: got %b want 0", mem_done); end
   endtask

   task automatic test_mem_timeout();
      logic seen_done = 1'b0;
      mem_start = 1; mem_we = 0;
      tick();
      for (int i = 1; i <= 14; i++) begin
         mem_start = (i <= 3);
         if (i == 2) begin gate_pc = 1; ld_mar = 1; end
         tick();
         clear_ctrl();
         if (mem_done === 1'b1 || mem_req !== 1'b1) seen_done = 1'b1;
      end
      vectors++; if (seen_done !== 1'b0) begin miscompares++; $display("FAIL to_early: done or req dropped before cycle 15, want busy"); end
      vectors++; if (mar !== 16'h3000 || mem_addr !== 16'h0040) begin miscompares++; $display("FAIL to_mar_busy: mar %h addr %h want 3000 0040", mar, mem_addr); end
      tick();
      vectors++; if (mem_done !== 1'b1 || mem_err !== 1'b1) begin miscompares++; $display("FAIL to_pulse: done %b err %b want 1 1", mem_done, mem_err); end
      vectors++; if (mem_req !== 1'b0 || mdr !== 16'hABCD) begin miscompares++; $display("FAIL to_state: req %b mdr %h want 0 ABCD", mem_req, mdr); end
      tick();
      vectors++; if (mem_done !== 1'b0 || mem_err !== 1'b0) begin miscompares++; $display("FAIL to_pulse_end: done %b err %b want 0 0", mem_done, mem_err); end
   endtask

   task automatic test_ben();
      set_ir(16'h0200);
      ld_ben = 1;
      tick();
      clear_ctrl();
      vectors++; if (ben !== 1'b0) begin miscompares++; $display("FAIL ben_brp: got %b want 0", ben); end
      set_ir(16'h0800);
      ld_ben = 1;
      tick();
      clear_ctrl();
      vectors++; if (ben !== 1'b1) begin miscompares++; $display("FAIL ben_brn: got %b want 1", ben); end
   endtask

   task automatic test_pc();
      load_mdr(16'hFFFF);
      gate_mdr = 1; pcmux = 2'b10; ld_pc = 1;
      tick();
      clear_ctrl();
      vectors++; if (pc !== 16'hFFFF) begin miscompares++; $display("FAIL pc_bus: got %h want FFFF", pc); end
      pcmux = 2'b00; ld_pc = 1;
      tick();
      clear_ctrl();
      vectors++; if (pc !== 16'h0000) begin miscompares++; $display("FAIL pc_wrap: got %h want 0000", pc); end
      pcmux = 2'b11; ld_pc = 1;
      tick();
      clear_ctrl();
      vectors++; if (pc !== 16'h0000) begin miscompares++; $display("FAIL pc_hold: got %h want 0000", pc); end
      set_ir(16'h07FE);
      pcmux = 2'b01; addr1mux = 0; addr2mux = 2'b11; ld_pc = 1;
      tick();
      clear_ctrl();
      vectors++; if (pc !== 16'hFFFE) begin miscompares++; $display("FAIL pc_adder: got %h want FFFE", pc); end
      gate_marmux = 1; addr1mux = 0; addr2mux = 2'b01; ld_mar = 1;
      tick();
      clear_ctrl();
      vectors++; if (mar !== 16'hFFFC) begin miscompares++; $display("FAIL marmux: got %h want FFFC", mar); end
   endtask

   task automatic test_reset_mid_access();
      mem_start = 1;
      tick();
      mem_start = 0;
      vectors++; if (mem_req !== 1'b1) begin miscompares++; $display("FAIL mid_busy: got %b want 1", mem_req); end
      #2 reset = 1;
      #1;
      vectors++; if (mem_req !== 1'b0 || pc !== 16'h3000 || bus_err !== 1'b0) begin miscompares++; $display("FAIL mid_reset: req %b pc %h bus_err %b want 0 3000 0", mem_req, pc, bus_err); end
      #2 reset = 0;
      tick();
      vectors++; if (mem_done !== 1'b0 || mem_req !== 1'b0) begin miscompares++; $display("FAIL mid_after: done %b req %b want 0 0", mem_done, mem_req); end
   endtask

   initial begin
      clear_ctrl();
      reset = 1;
      repeat (2) @(posedge clk);
      #1;
      test_reset();
      reset = 0;
      tick();
      test_add_cc();
      test_alu_ops();
      test_bus_contention();
      test_mem_read();
      test_mem_write();
      test_mem_timeout();
      test_ben();
      test_pc();
      test_reset_mid_access();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
